// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: fetch FSM encoding,
// default PC geometry and instruction width.
package ifu_pkg;

  localparam int          PC_W_DEFAULT     = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam int          INST_W           = 32;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_npc_sel.sv
// Next fetch-PC selection: ID redirect beats a predicted-taken target, which
// beats the sequential +4 path; the PC only moves on redirect or handshake.
module ifu_npc_sel #(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  input  logic            pred_jump,
  input  logic [PC_W-1:0] pred_branch,
  output logic [PC_W-1:0] npc
);

  always_comb begin
    // NOTE: assign every combinational output a default first so no path
    // through the if/else chain leaves it unassigned and infers a latch.
    npc = pc;
    if (redirect) begin
      npc = redirect_pc;
    end else if (advance) begin
      // Sequential path wraps naturally at 2^PC_W.
      npc = pred_jump ? pred_branch : pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/ifu_pcgen.sv
// Fetch PC owner and fetch request sequencer: issues one request at a time,
// drops stale responses after a redirect, and holds one instruction for ID.
module ifu_pcgen
  import ifu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT[PC_W-1:0]
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pred_jump,
  input  logic [PC_W-1:0]   pred_branch,
  input  logic              id_redirect,
  input  logic [PC_W-1:0]   id_redirect_pc,
  input  logic              stall,
  output logic [PC_W-1:0]   pc,
  output logic              pc_ready,
  output logic              nop,
  output logic              if_req_valid,
  input  logic              if_req_ready,
  input  logic              if_rsp_valid,
  input  logic [INST_W-1:0] if_rsp_inst,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic [PC_W-1:0]   if_pred_target
);

  ifu_state_t state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;

  logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
  logic              infl_taken_q, infl_taken_d;
  logic [PC_W-1:0]   infl_target_q, infl_target_d;

  logic              slot_valid_q, slot_valid_d;
  logic [INST_W-1:0] slot_inst_q, slot_inst_d;
  logic [PC_W-1:0]   slot_pc_q, slot_pc_d;
  logic              slot_taken_q, slot_taken_d;
  logic [PC_W-1:0]   slot_target_q, slot_target_d;

  logic              req_valid;
  logic              req_fire;
  logic              rsp_load;

  // A request may issue only when the slot will have room by the time its
  // response lands; reset gates the combinational handshake outputs low.
  assign req_valid = (state_q == ST_REQ) & (~slot_valid_q | ~stall)
                   & ~id_redirect & ~reset;
  assign req_fire  = req_valid & if_req_ready;
  assign rsp_load  = (state_q == ST_WAIT) & if_rsp_valid & ~id_redirect;

  ifu_npc_sel #(.PC_W(PC_W)) u_npc_sel (
    .pc          (pc_q),
    .redirect    (id_redirect),
    .redirect_pc (id_redirect_pc),
    .advance     (req_fire),
    .pred_jump   (pred_jump),
    .pred_branch (pred_branch),
    .npc         (pc_d)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_REQ:  if (req_fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (if_rsp_valid)     state_d = ST_REQ;
        else if (id_redirect) state_d = ST_DROP;
      end
      ST_DROP: if (if_rsp_valid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    infl_pc_d     = infl_pc_q;
    infl_taken_d  = infl_taken_q;
    infl_target_d = infl_target_q;
    slot_valid_d  = slot_valid_q;
    slot_inst_d   = slot_inst_q;
    slot_pc_d     = slot_pc_q;
    slot_taken_d  = slot_taken_q;
    slot_target_d = slot_target_q;

    if (req_fire) begin
      infl_pc_d     = pc_q;
      infl_taken_d  = pred_jump;
      infl_target_d = pred_branch;
    end

    // Flush beats load, and load beats drain.
    if (id_redirect) begin
      slot_valid_d = 1'b0;
    end else if (rsp_load) begin
      slot_valid_d  = 1'b1;
      slot_inst_d   = if_rsp_inst;
      slot_pc_d     = infl_pc_q;
      slot_taken_d  = infl_taken_q;
      slot_target_d = infl_target_q;
    end else if (slot_valid_q & ~stall) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      infl_pc_q     <= '0;
      infl_taken_q  <= 1'b0;
      infl_target_q <= '0;
      slot_valid_q  <= 1'b0;
      slot_inst_q   <= '0;
      slot_pc_q     <= '0;
      slot_taken_q  <= 1'b0;
      slot_target_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      infl_pc_q     <= infl_pc_d;
      infl_taken_q  <= infl_taken_d;
      infl_target_q <= infl_target_d;
      slot_valid_q  <= slot_valid_d;
      slot_inst_q   <= slot_inst_d;
      slot_pc_q     <= slot_pc_d;
      slot_taken_q  <= slot_taken_d;
      slot_target_q <= slot_target_d;
    end
  end

  assign pc             = pc_q;
  assign if_req_valid   = req_valid;
  assign pc_ready       = req_fire;
  assign nop            = id_redirect & ~reset;
  assign if_valid       = slot_valid_q;
  assign if_inst        = slot_inst_q;
  assign if_pc          = slot_pc_q;
  assign if_pred_taken  = slot_taken_q;
  assign if_pred_target = slot_target_q;

endmodule

// File: doc/ifu_pcgen.md
# ifu_pcgen

Fetch-address generator and instruction-fetch request sequencer at the front of the pipeline. It owns the architectural fetch PC and presents it to the branch predictor and the instruction memory port. It selects the next PC from sequential, predicted-taken and ID-stage redirect sources. It also registers each returned instruction, with its PC and prediction, into a one-entry slot that feeds the IF/ID boundary.

## Interface
- `PC_W`, 64: fetch PC width.
- `RESET_PC`, 64'h8000_0000: PC loaded on reset.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `pred_jump` in 1: predictor taken decision for current `pc` (combinational from predictor).
- `pred_branch` in PC_W: predictor target for current `pc`.
- `id_redirect` in 1: ID detected mispredict or jump; flush and refetch.
- `id_redirect_pc` in PC_W: correct next PC.
- `stall` in 1: ID cannot accept the slot this cycle.
- `pc` out PC_W: current fetch PC, to predictor and memory.
- `pc_ready` out 1: request handshake fired this cycle (`if_req_valid & if_req_ready`). Predictor advances on it.
- `nop` out 1: equals `id_redirect`. Tells the predictor the current lookup is void.
- `if_req_valid` out 1: fetch request to instruction memory.
- `if_req_ready` in 1: memory accepts request.
- `if_rsp_valid` in 1: response for the oldest outstanding request.
- `if_rsp_inst` in 32: returned instruction.
- `if_valid` out 1: slot holds a valid instruction for ID.
- `if_inst` out 32, `if_pc` out PC_W: slot contents.
- `if_pred_taken` out 1, `if_pred_target` out PC_W: prediction made for `if_pc`.

## Operation
- States: `REQ` (present `pc`), `WAIT` (one request outstanding), `DROP` (outstanding request is stale; discard its response).
- `if_req_valid = (state==REQ) & (~if_valid | ~stall) & ~id_redirect`.
- On handshake in REQ:
  - latch `pc`, `pred_jump`, `pred_branch` into in-flight registers.
  - `pc <= pred_jump ? pred_branch : pc + 4`, wrapping mod 2^PC_W.
  - go to WAIT.
- WAIT with `if_rsp_valid`:
  - load slot from response plus in-flight registers; `if_valid <= 1`.
  - go to REQ.
- Slot drains when `if_valid & ~stall`. A load and a drain in the same cycle: the load wins.
- DROP with `if_rsp_valid`: discard the response, go to REQ. The slot is untouched.
- `id_redirect` has top priority in every state:
  - `pc <= id_redirect_pc`; `if_valid <= 0`.
  - No request is issued that cycle.
  - WAIT goes to DROP. DROP stays DROP unless `if_rsp_valid`, in which case it goes to REQ. REQ stays REQ.
  - A response arriving in WAIT in the redirect cycle is discarded, and the state goes to REQ.
- At most one outstanding request. Responses return in order.

## Timing
- Reset values:
  - `pc = RESET_PC`, state REQ.
  - `if_valid = 0`, `if_inst = 0`, `if_pc = 0`, `if_pred_taken = 0`, `if_pred_target = 0`.
  - `pc_ready = 0`, `nop = 0`, `if_req_valid = 0` while reset is asserted.
- Reset asserted mid-transfer: an outstanding response after reset release is not expected. Memory is reset by the same signal.
- Handshake in cycle N, `if_rsp_valid` in N+k (k≥1), `if_valid` high from N+k+1.
- Best-case throughput is one instruction per 2 cycles.
- A redirect in cycle N gives the new PC on `pc` in N+1. The earliest request for it is in N+1.
- `pc_ready`, `nop` and `if_req_valid` are combinational. All other outputs are registered.

## Structure
- Shared package `ifu_pkg`:
  - state encoding `ifu_state_t` (REQ=0, WAIT=1, DROP=2);
  - `PC_W` and `RESET_PC` defaults;
  - `INST_W=32`.
- The in-flight and slot registers stay in the top. An optional sub-module `ifu_npc_sel` holds the combinational next-PC mux (redirect > predicted > +4).

## Test plan
- Reset release, `if_req_ready=1`, 1-cycle responses, no prediction → `if_pc` sequence 0x80000000, 0x80000004, 0x80000008. `if_valid` first high 2 cycles after the first handshake.
- `pred_jump=1`, `pred_branch=0x80000100` at `pc=0x80000004` → next fetched `pc=0x80000100`. Slot shows `if_pred_taken=1`, `if_pred_target=0x80000100`.
- Redirect to 0x80000200 while in WAIT → that response is discarded (no `if_valid`). Next handshake uses `pc=0x80000200`.
- `stall=1` held 3 cycles with slot full → `if_req_valid=0`, slot stable. On release, slot drains and a new request issues the same cycle.
- `id_redirect` coincident with `if_rsp_valid` in WAIT → slot not loaded, `if_valid=0`, state REQ, `pc=id_redirect_pc`.
- `pc=0xFFFF_FFFF_FFFF_FFFC` sequential → next `pc=0`. Reset asserted in WAIT → outputs at reset values immediately, without waiting for a clock edge.
